// File: rtl/tiny_alu_seq_if.sv
// Request/response bundle between the control FSM and the execute unit.
// Master issues start/op/a/b; slave returns busy/done/result/flags.
interface tiny_alu_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    modport master (output start, op, a, b,
                    input  busy, done, result, zero, carry);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, zero, carry);
endinterface

// File: rtl/tiny_alu_seq.sv
// Multi-cycle execute unit: 1-cycle ALU ops, iterative shifts and shift-add multiply.
// Latency: 1 cycle ALU, max(1,b[2:0]) shifts, WIDTH cycles MUL; done pulses for one cycle.
// Backpressure: start is only sampled while busy is low; requests during RUN are dropped.
module tiny_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tiny_alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               last;
    logic [CW-1:0]      cnt, cnt_init;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] opa, opa_nxt;   // operand A, shift register, or multiplicand
    logic [WIDTH-1:0]   opb, opb_nxt;   // operand B, shift amount, or multiplier
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH-1:0]   res_nxt, result_q;
    logic               c_nxt, zero_q, carry_q;
    logic               busy_c, done_c;

    assign last = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                accept = bus.start;
                if (bus.start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_c    = 1'b1;
                accept    = bus.start;
                state_nxt = bus.start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Number of RUN cycles minus one, so the final iteration sees cnt == 0.
    always_comb begin
        cnt_init = '0;
        case (bus.op)
            OP_SHL, OP_SHR: if (bus.b[CW-1:0] != '0) cnt_init = bus.b[CW-1:0] - CW'(1);
            OP_MUL:         cnt_init = CW'(WIDTH - 1);
            default:        cnt_init = '0;
        endcase
    end

    always_comb begin
        opa_nxt  = opa;
        opb_nxt  = opb;
        prod_nxt = prod;
        res_nxt  = '0;
        c_nxt    = 1'b0;
        case (op_q)
            OP_ADD: {c_nxt, res_nxt} = {1'b0, opa[WIDTH-1:0]} + {1'b0, opb};
            OP_SUB: begin
                res_nxt = opa[WIDTH-1:0] - opb;
                c_nxt   = (opa[WIDTH-1:0] < opb);
            end
            OP_AND: res_nxt = opa[WIDTH-1:0] & opb;
            OP_OR:  res_nxt = opa[WIDTH-1:0] | opb;
            OP_XOR: res_nxt = opa[WIDTH-1:0] ^ opb;
            OP_SHL: begin
                if (opb[CW-1:0] == '0) begin
                    res_nxt = opa[WIDTH-1:0];
                end else begin
                    opa_nxt = {{WIDTH{1'b0}}, opa[WIDTH-2:0], 1'b0};
                    c_nxt   = opa[WIDTH-1];
                    res_nxt = opa_nxt[WIDTH-1:0];
                end
            end
            OP_SHR: begin
                if (opb[CW-1:0] == '0) begin
                    res_nxt = opa[WIDTH-1:0];
                end else begin
                    opa_nxt = {{WIDTH{1'b0}}, 1'b0, opa[WIDTH-1:1]};
                    c_nxt   = opa[0];
                    res_nxt = opa_nxt[WIDTH-1:0];
                end
            end
            OP_MUL: begin
                prod_nxt = prod + (opb[0] ? opa : '0);
                opa_nxt  = {opa[2*WIDTH-2:0], 1'b0};
                opb_nxt  = {1'b0, opb[WIDTH-1:1]};
                res_nxt  = prod_nxt[WIDTH-1:0];
                c_nxt    = |prod_nxt[2*WIDTH-1:WIDTH];
            end
            default: res_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            opa      <= '0;
            opb      <= '0;
            prod     <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else if (accept) begin
            op_q <= bus.op;
            opa  <= {{WIDTH{1'b0}}, bus.a};
            opb  <= bus.b;
            prod <= '0;
            cnt  <= cnt_init;
        end else if (state == S_RUN) begin
            opa  <= opa_nxt;
            opb  <= opb_nxt;
            prod <= prod_nxt;
            if (last) begin
                result_q <= res_nxt;
                zero_q   <= (res_nxt == '0);
                carry_q  <= c_nxt;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
endmodule
